// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking fully-connected layer sequencer.
package snn_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    ACCUM,
    ACTIV,
    WAIT,
    CAPTURE,
    EMIT
  } seq_state_t;

  // Cycles from the en_activ pulse until the core's post_syn_spk is valid.
  localparam int ACTIV_TO_SPK = 2;

endpackage

// File: rtl/spk_addr_buf.sv
// Spike address buffer: single write port, combinational read, fill count.
// Writes past DEPTH are dropped; the owner flags the overflow.
module spk_addr_buf
  import snn_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int WIDTH = 6,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (wr_en && !full) begin
      mem[count[IW-1:0]] <= wr_data;
      count              <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Sequencer for one time-multiplexed FC neuron core: buffers a step of spikes,
// replays them per neuron and gathers the output spike vector. Option: FC_SEQ_SPK_CNT_EN.
module fc_layer_seq
  import snn_pkg::*;
#(
  parameter int INPUT_FRAME_SIZE = 28,
  parameter int LAYER_SIZE       = 10,
  parameter int NUM_STEPS        = 25,
  parameter int AW               = $clog2(INPUT_FRAME_SIZE) + 1,
  parameter int NW               = $clog2(LAYER_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_eos,
  input  logic [AW-1:0]         in_addr,
  output logic                  en_accum,
  output logic                  en_activ,
  output logic [NW-1:0]         neuron,
  output logic [AW-1:0]         spk_addr,
  output logic                  last_time_step,
  input  logic                  post_syn_spk,
  output logic                  out_valid,
  output logic [LAYER_SIZE-1:0] out_spk,
  output logic                  done,
  output logic                  ovf
`ifdef FC_SEQ_SPK_CNT_EN
  ,
  output logic [LAYER_SIZE*$clog2(NUM_STEPS+1)-1:0] spk_cnt,
  output logic [NW-1:0]         class_idx
`endif
);

  localparam int CW          = $clog2(INPUT_FRAME_SIZE + 1);
  localparam int IW          = (INPUT_FRAME_SIZE > 1) ? $clog2(INPUT_FRAME_SIZE) : 1;
  localparam int SW          = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int NIW         = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;
  localparam int WAIT_CYCLES = ACTIV_TO_SPK - 1;

  seq_state_t            state;
  logic [CW-1:0]         count;
  logic [CW-1:0]         idx;
  logic [SW-1:0]         step;
  logic [NW-1:0]         n;
  logic [NIW-1:0]        n_lo;
  logic [1:0]            wait_cnt;
  logic [LAYER_SIZE-1:0] out_spk_reg;
  logic [LAYER_SIZE-1:0] spk_vec_nxt;
  logic [AW-1:0]         rd_data;
  logic [IW-1:0]         rd_idx;
  logic                  beat;
  logic                  wr_en;
  logic                  buf_full;
  logic                  buf_clr;

  // in_ready is high exactly while the FSM sits in LOAD.
  assign beat    = in_valid && in_ready;
  assign wr_en   = beat && !in_eos;
  assign buf_clr = (state == EMIT);
  assign rd_idx  = (state == ACCUM) ? idx[IW-1:0] : '0;
  assign n_lo    = n[NIW-1:0];
  assign neuron  = n;

  spk_addr_buf #(
    .DEPTH(INPUT_FRAME_SIZE),
    .WIDTH(AW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (buf_clr),
    .wr_en  (wr_en),
    .wr_data(in_addr),
    .rd_idx (rd_idx),
    .rd_data(rd_data),
    .count  (count),
    .full   (buf_full)
  );

  always_comb begin
    spk_vec_nxt       = out_spk_reg;
    spk_vec_nxt[n_lo] = post_syn_spk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      step           <= '0;
      n              <= '0;
      idx            <= '0;
      wait_cnt       <= '0;
      in_ready       <= 1'b1;
      en_accum       <= 1'b0;
      en_activ       <= 1'b0;
      spk_addr       <= '0;
      last_time_step <= 1'b0;
      out_valid      <= 1'b0;
      out_spk        <= '0;
      out_spk_reg    <= '0;
      done           <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      en_accum  <= 1'b0;
      en_activ  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (wr_en && buf_full) ovf <= 1'b1;
      case (state)
        LOAD: begin
          if (beat && in_eos) begin
            state          <= START;
            in_ready       <= 1'b0;
            n              <= '0;
            en_accum       <= 1'b1;
            last_time_step <= (step == SW'(NUM_STEPS - 1));
          end
        end
        START: begin
          if (count == '0) begin
            state    <= ACTIV;
            en_activ <= 1'b1;
          end else begin
            state    <= ACCUM;
            spk_addr <= rd_data;
            idx      <= CW'(1);
          end
        end
        // idx points one past the address currently on spk_addr.
        ACCUM: begin
          if (idx == count) begin
            state    <= ACTIV;
            en_activ <= 1'b1;
          end else begin
            spk_addr <= rd_data;
            idx      <= idx + CW'(1);
          end
        end
        ACTIV: begin
          state    <= WAIT;
          spk_addr <= '0;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == 2'(WAIT_CYCLES - 1)) state <= CAPTURE;
          else wait_cnt <= wait_cnt + 2'd1;
        end
        CAPTURE: begin
          out_spk_reg <= spk_vec_nxt;
          if (n == NW'(LAYER_SIZE - 1)) begin
            state          <= EMIT;
            out_valid      <= 1'b1;
            out_spk        <= spk_vec_nxt;
            last_time_step <= 1'b0;
            n              <= '0;
          end else begin
            state    <= START;
            n        <= n + NW'(1);
            en_accum <= 1'b1;
          end
        end
        EMIT: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          if (step == SW'(NUM_STEPS - 1)) begin
            step <= '0;
            done <= 1'b1;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef FC_SEQ_SPK_CNT_EN
  localparam int CNTW = $clog2(NUM_STEPS + 1);

  logic [CNTW-1:0] cnt [LAYER_SIZE];
  logic [NW-1:0]   best_idx;
  logic [CNTW-1:0] best_val;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = cnt[0];
    for (int i = 1; i < LAYER_SIZE; i++) begin
      if (cnt[i] > best_val) begin
        best_val = cnt[i];
        best_idx = NW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || done) begin
      for (int i = 0; i < LAYER_SIZE; i++) cnt[i] <= '0;
    end else if (state == CAPTURE && post_syn_spk) begin
      cnt[n_lo] <= cnt[n_lo] + CNTW'(1);
    end
    if (rst) class_idx <= '0;
    else if (state == EMIT && step == SW'(NUM_STEPS - 1)) class_idx <= best_idx;
  end

  for (genvar i = 0; i < LAYER_SIZE; i++) begin : g_cnt
    assign spk_cnt[i*CNTW +: CNTW] = cnt[i];
  end
`endif

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Initiator/sequencer driving one time-multiplexed FC neuron core, the block that consumes en_accum/en_activ/neuron/spk_addr/last_time_step and returns post_syn_spk.
- Buffers one time step of input spike addresses, then replays them back-to-back once per output neuron.
- Collects each neuron's post_syn_spk into a per-step output spike vector.
- Repeats for NUM_STEPS time steps per inference.

Parameters:
- INPUT_FRAME_SIZE, 28: spike-buffer depth; spk_addr range.
- LAYER_SIZE, 10: neurons sequenced per step.
- NUM_STEPS, 25: time steps per inference.
- AW, $clog2(INPUT_FRAME_SIZE)+1: spike address width.
- NW, $clog2(LAYER_SIZE)+1: neuron index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_eos  in  1  end-of-step beat; carries no address
- in_addr  in  AW  input spike address; ignored when in_eos=1
- en_accum  out  1  one-cycle pulse opening a neuron pass
- en_activ  out  1  one-cycle pulse closing a neuron pass
- neuron  out  NW  current neuron index
- spk_addr  out  AW  replayed spike address
- last_time_step  out  1  high during the pass when step==NUM_STEPS-1
- post_syn_spk  in  1  core spike result, registered
- out_valid  out  1  one-cycle pulse: out_spk valid
- out_spk  out  LAYER_SIZE  spike vector of the finished step, bit n = neuron n
- done  out  1  one-cycle pulse after the last step's out_valid
- ovf  out  1  sticky: step exceeded INPUT_FRAME_SIZE events

Behaviour:
- Reset (sync, any state):
  - state=LOAD; step=0; count=0.
  - All outputs 0; in_ready=1. ovf clears only on rst.
- LOAD:
  - in_ready=1.
  - Each accepted non-eos beat writes in_addr to buf[count] and increments count.
  - When count==INPUT_FRAME_SIZE, further addresses are dropped and ovf is set; in_ready stays 1.
  - An accepted eos beat goes to START with n=0; in_ready=0 from the next cycle.
- START: en_accum=1 for one cycle; next state ACCUM with idx=0.
- ACCUM:
  - One buffered address per cycle, no bubbles: spk_addr=buf[idx], idx++.
  - After the cycle with idx==count-1, go to ACTIV.
  - count==0: ACCUM is skipped, so en_activ follows the en_accum cycle directly.
- ACTIV: en_activ=1 for one cycle (cycle A); spk_addr holds its last value.
- WAIT: one cycle (A+1), while the core evaluates.
- CAPTURE (A+2):
  - out_spk_reg[n] <= post_syn_spk.
  - If n<LAYER_SIZE-1: n++ and go to START. The next en_accum is never earlier than A+2.
  - Else go to EMIT.
- EMIT:
  - out_valid=1 and out_spk=out_spk_reg; out_spk holds until the next EMIT.
  - count=0.
  - If step==NUM_STEPS-1: done=1 next cycle, step=0. Otherwise step++.
  - Return to LOAD.
- Pass outputs:
  - neuron=n, held stable from START through CAPTURE.
  - last_time_step=(step==NUM_STEPS-1), held for the whole pass.
  - spk_addr=0 outside ACCUM/ACTIV.
- Per-step latency after eos: LAYER_SIZE*(count+4)+1 cycles to out_valid.
- Buffer: plain register/LUT array, combinational read, written only in LOAD.
- Input beats are never accepted outside LOAD. in_valid may stay high; the beat waits.

Optional Feature:
- FC_SEQ_SPK_CNT_EN defined:
  - Adds output spk_cnt (LAYER_SIZE*$clog2(NUM_STEPS+1) bits): per-neuron spike counters, incremented in CAPTURE when post_syn_spk=1.
  - Adds output class_idx (NW): argmax of the counters, lowest index wins ties. Valid with done.
  - Counters clear on rst and on the cycle after done.
- FC_SEQ_SPK_CNT_EN undefined: the ports and logic are absent.

Decomposition:
- Shared package snn_pkg:
  - State enum typedef (LOAD, START, ACCUM, ACTIV, WAIT, CAPTURE, EMIT).
  - Core handshake latency constant ACTIV_TO_SPK=2.
- One sub-module, spk_addr_buf: depth/width parameterized, single write port, combinational read, count output.

Test Plan:
- Step with addrs {3,7,12} then eos, LAYER_SIZE=2, core model spikes neuron 1 only:
  - Per pass: en_accum, then spk_addr 3,7,12 on consecutive cycles, then en_activ.
  - out_valid with out_spk=2'b10 at 2*(3+4)+1=15 cycles after eos.
- Zero-event step (eos only): en_activ exactly one cycle after each en_accum; out_valid follows.
- 30 addresses into INPUT_FRAME_SIZE=28: ovf=1, only first 28 replayed, in_ready never drops during LOAD.
- NUM_STEPS=3, constant traffic:
  - last_time_step high only during step 2 passes.
  - done pulses once, one cycle after the third out_valid.
  - step restarts at 0.
- rst asserted mid-ACCUM: next cycle en_accum/en_activ/out_valid=0, in_ready=1, ovf=0, buffer count 0.
- FC_SEQ_SPK_CNT_EN, NUM_STEPS=4, neuron 2 spikes 3 steps, neuron 5 spikes 3 steps: class_idx=2 at done.
